exe_pipe: RTL and testbench

Parametrised, registered execute stage for the MyProc pipeline, replacing the combinational execute block. It sits between operand fetch/decode and memory access. It accepts one decoded operation per `in_valid`/`in_ready` handshake and returns a registered result, condition flags and branch resolution through an `out_valid`/`out_ready` handshake. It adds an iterative shift-add multiplier, a flush input and backpressure.

---
 rtl/exe_pipe_pkg.sv | 48 ++++
 rtl/exe_mul_iter.sv | 47 ++++
 rtl/exe_pipe.sv | 171 +++++++++++++++++
 tb/tb_exe_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pipe_pkg.sv
// Shared ISA opcodes, condition-flag bit positions and execute-stage FSM encoding.
package exe_pipe_pkg;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_ADDI = 6'd2;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd4;
    localparam logic [5:0] OP_ANDI = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_ORI  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLL  = 6'd9;
    localparam logic [5:0] OP_SRL  = 6'd10;
    localparam logic [5:0] OP_SLLV = 6'd11;
    localparam logic [5:0] OP_SRLV = 6'd12;
    localparam logic [5:0] OP_SRA  = 6'd13;
    localparam logic [5:0] OP_LUI  = 6'd14;
    localparam logic [5:0] OP_LW   = 6'd15;
    localparam logic [5:0] OP_LH   = 6'd16;
    localparam logic [5:0] OP_LD   = 6'd17;
    localparam logic [5:0] OP_SW   = 6'd18;
    localparam logic [5:0] OP_SH   = 6'd19;
    localparam logic [5:0] OP_SD   = 6'd20;
    localparam logic [5:0] OP_BEQ  = 6'd21;
    localparam logic [5:0] OP_BNE  = 6'd22;
    localparam logic [5:0] OP_BGTZ = 6'd23;
    localparam logic [5:0] OP_BLTZ = 6'd24;
    localparam logic [5:0] OP_BLEZ = 6'd25;
    localparam logic [5:0] OP_BGEZ = 6'd26;
    localparam logic [5:0] OP_J    = 6'd27;
    localparam logic [5:0] OP_JR   = 6'd28;
    localparam logic [5:0] OP_JAL  = 6'd29;
    localparam logic [5:0] OP_JALR = 6'd30;
    localparam logic [5:0] OP_MUL  = 6'd31;
    localparam logic [5:0] OP_HALT = 6'd63;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } exe_state_t;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps.
module exe_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   count;
    logic [WIDTH:0]     partial;

    // product is the accumulator after this cycle's step, so the final step
    // can be captured by the consumer on the same edge that completes it
    always_comb begin
        partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        product = {partial, acc[WIDTH-1:1]};
    end

    assign done = (count == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
            count <= '0;
        end else if (abort) begin
            count <= '0;
        end else if (start) begin
            mcand <= mcand_in;
            acc   <= {{WIDTH{1'b0}}, mplier_in};
            count <= CNT_W'(WIDTH);
        end else if (count != '0) begin
            acc   <= product;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/exe_pipe.sv
// Registered execute stage: single-cycle ALU/shift/branch ops plus iterative MUL,
// with valid/ready handshakes on both sides and a synchronous flush.
module exe_pipe
    import exe_pipe_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PC_W    = WIDTH - 2,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         op,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [PC_W-1:0]    pc_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   z,
    output logic [3:0]         flags,
    output logic               branch_taken,
    output logic [PC_W-1:0]    branch_addr,
    output logic               illegal,
    output logic               busy
);
    exe_state_t state;

    logic accept, start_mul, load_single, mul_done, mul_iter_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]         sum;
    logic [WIDTH-1:0]       diff;
    logic [SHAMT_W-1:0]     amt;
    logic [WIDTH:0]         sll_t, srl_t, sra_t;
    logic signed [WIDTH:0]  sra_src;
    logic                   x_zero, x_neg;
    logic [PC_W-1:0]        br_tgt, reg_tgt;

    logic [WIDTH-1:0] res_z, ld_z;
    logic [3:0]       res_f, ld_f, mul_f;
    logic             res_br, res_ill, upd_zn;
    logic [PC_W-1:0]  res_addr;

    assign in_ready    = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign start_mul   = accept && (op == OP_MUL);
    assign load_single = accept && (op != OP_MUL);
    assign mul_done    = (state == S_MUL) && mul_iter_done;
    assign busy        = (state == S_MUL);

    exe_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_mul && !flush),
        .abort     (flush),
        .mcand_in  (x),
        .mplier_in (y),
        .done      (mul_iter_done),
        .product   (mul_product)
    );

    // Shifts carry one extra guard bit so the last bit shifted out lands in C,
    // and a zero shift amount naturally yields C=0.
    assign amt     = (op == OP_SLLV || op == OP_SRLV) ? y[SHAMT_W-1:0] : shamt;
    assign sra_src = {x, 1'b0};
    assign sum     = {1'b0, x} + {1'b0, y};
    assign diff    = x - y;
    assign sll_t   = {1'b0, x} << amt;
    assign srl_t   = {x, 1'b0} >> amt;
    assign sra_t   = sra_src >>> amt;
    assign x_zero  = (x == '0);
    assign x_neg   = x[WIDTH-1];
    assign br_tgt  = pc_in + PC_W'(y << 2);
    assign reg_tgt = PC_W'(x + y);

    always_comb begin
        res_z    = '0;
        res_f    = flags;
        res_br   = 1'b0;
        res_addr = '0;
        res_ill  = 1'b0;
        upd_zn   = 1'b0;
        unique case (op)
            OP_ADD, OP_ADDI: begin
                res_z         = sum[WIDTH-1:0];
                res_f[FLAG_C] = sum[WIDTH];
                res_f[FLAG_V] = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
                upd_zn        = 1'b1;
            end
            OP_SUB: begin
                res_z         = diff;
                res_f[FLAG_C] = (x < y);
                res_f[FLAG_V] = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
                upd_zn        = 1'b1;
            end
            OP_AND, OP_ANDI: begin res_z = x & y; upd_zn = 1'b1; end
            OP_OR,  OP_ORI:  begin res_z = x | y; upd_zn = 1'b1; end
            OP_XOR:          begin res_z = x ^ y; upd_zn = 1'b1; end
            OP_SLL, OP_SLLV: begin
                res_z = sll_t[WIDTH-1:0]; res_f[FLAG_C] = sll_t[WIDTH]; upd_zn = 1'b1;
            end
            OP_SRL, OP_SRLV: begin
                res_z = srl_t[WIDTH:1]; res_f[FLAG_C] = srl_t[0]; upd_zn = 1'b1;
            end
            OP_SRA: begin
                res_z = sra_t[WIDTH:1]; res_f[FLAG_C] = sra_t[0]; upd_zn = 1'b1;
            end
            OP_LUI: res_z = y << 16;
            OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD: res_z = sum[WIDTH-1:0];
            OP_BEQ:  begin res_br = x_zero;            res_addr = br_tgt; end
            OP_BNE:  begin res_br = !x_zero;           res_addr = br_tgt; end
            OP_BGTZ: begin res_br = !x_neg && !x_zero; res_addr = br_tgt; end
            OP_BLTZ: begin res_br = x_neg;             res_addr = br_tgt; end
            OP_BLEZ: begin res_br = x_neg || x_zero;   res_addr = br_tgt; end
            OP_BGEZ: begin res_br = !x_neg;            res_addr = br_tgt; end
            OP_J:    begin res_br = 1'b1; res_addr = PC_W'(x); end
            OP_JAL:  begin res_br = 1'b1; res_addr = PC_W'(x); res_z = WIDTH'(PC_W'(x)); end
            OP_JR:   begin res_br = 1'b1; res_addr = reg_tgt; end
            OP_JALR: begin res_br = 1'b1; res_addr = reg_tgt; res_z = WIDTH'(reg_tgt); end
            OP_NOP, OP_HALT, OP_MUL: ;
            default: res_ill = 1'b1;
        endcase
        if (upd_zn) begin
            res_f[FLAG_Z] = (res_z == '0);
            res_f[FLAG_N] = res_z[WIDTH-1];
        end
    end

    always_comb begin
        mul_f         = '0;
        mul_f[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
        mul_f[FLAG_V] = |mul_product[2*WIDTH-1:WIDTH];
        mul_f[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
        mul_f[FLAG_N] = mul_product[WIDTH-1];
        ld_z          = mul_done ? mul_product[WIDTH-1:0] : res_z;
        ld_f          = mul_done ? mul_f : res_f;
    end

    // flush outranks both a new accept and a completing multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            out_valid    <= 1'b0;
            z            <= '0;
            flags        <= '0;
            branch_taken <= 1'b0;
            branch_addr  <= '0;
            illegal      <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            if (start_mul)     state <= S_MUL;
            else if (mul_done) state <= S_IDLE;
            if (load_single || mul_done) begin
                out_valid    <= 1'b1;
                z            <= ld_z;
                flags        <= ld_f;
                branch_taken <= mul_done ? 1'b0 : res_br;
                branch_addr  <= mul_done ? '0 : res_addr;
                illegal      <= mul_done ? 1'b0 : res_ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exe_pipe.sv
// Directed plus randomized bench for exe_pipe against an arithmetic reference model.
module tb_exe_pipe;
    import exe_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  op = '0;
    logic [31:0] x = '0, y = '0;
    logic [4:0]  shamt = '0;
    logic [29:0] pc_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] z;
    logic [3:0]  flags;
    logic        branch_taken;
    logic [29:0] branch_addr;
    logic        illegal;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [3:0]  mflags = '0;
    logic [31:0] ez;
    logic [3:0]  ef;
    logic        ebr, eill;
    logic [29:0] eaddr;

    exe_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .x(x), .y(y), .shamt(shamt), .pc_in(pc_in), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .flags(flags), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on the ISA rules.
    task automatic model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input logic [29:0] p);
        longint sa, sb, r;
        logic [32:0] w;
        logic [63:0] prod;
        int amt;
        bit zn;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ez = '0; ef = mflags; ebr = 1'b0; eaddr = '0; eill = 1'b0; zn = 0;
        amt = (o == OP_SLLV || o == OP_SRLV) ? int'(b[4:0]) : int'(s);
        case (o)
            OP_ADD, OP_ADDI: begin
                w = {1'b0, a} + {1'b0, b}; ez = w[31:0]; r = sa + sb;
                ef[FLAG_C] = w[32]; ef[FLAG_V] = (r > 64'sd2147483647) || (r < -64'sd2147483648); zn = 1;
            end
            OP_SUB: begin
                ez = a - b; r = sa - sb;
                ef[FLAG_C] = (a < b); ef[FLAG_V] = (r > 64'sd2147483647) || (r < -64'sd2147483648); zn = 1;
            end
            OP_AND, OP_ANDI: begin ez = a & b; zn = 1; end
            OP_OR, OP_ORI:   begin ez = a | b; zn = 1; end
            OP_XOR:          begin ez = a ^ b; zn = 1; end
            OP_SLL, OP_SLLV: begin
                ez = a << amt; ef[FLAG_C] = (amt != 0) && (((a >> (32 - amt)) & 32'd1) != 0); zn = 1;
            end
            OP_SRL, OP_SRLV, OP_SRA: begin
                ez = (o == OP_SRA) ? 32'($signed(a) >>> amt) : a >> amt;
                ef[FLAG_C] = (amt != 0) && (((a >> (amt - 1)) & 32'd1) != 0); zn = 1;
            end
            OP_LUI: ez = b << 16;
            OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD: ez = a + b;
            OP_BEQ:  begin ebr = (sa == 0); eaddr = 30'(p + b * 4); end
            OP_BNE:  begin ebr = (sa != 0); eaddr = 30'(p + b * 4); end
            OP_BGTZ: begin ebr = (sa > 0);  eaddr = 30'(p + b * 4); end
            OP_BLTZ: begin ebr = (sa < 0);  eaddr = 30'(p + b * 4); end
            OP_BLEZ: begin ebr = (sa <= 0); eaddr = 30'(p + b * 4); end
            OP_BGEZ: begin ebr = (sa >= 0); eaddr = 30'(p + b * 4); end
            OP_J:    begin ebr = 1; eaddr = a[29:0]; end
            OP_JAL:  begin ebr = 1; eaddr = a[29:0]; ez = {2'b00, eaddr}; end
            OP_JR:   begin ebr = 1; eaddr = 30'(a + b); end
            OP_JALR: begin ebr = 1; eaddr = 30'(a + b); ez = {2'b00, eaddr}; end
            OP_MUL: begin
                prod = {32'd0, a} * {32'd0, b}; ez = prod[31:0];
                ef[FLAG_C] = (prod[63:32] != 0); ef[FLAG_V] = (prod[63:32] != 0); zn = 1;
            end
            OP_NOP, OP_HALT: ;
            default: eill = 1'b1;
        endcase
        if (zn) begin ef[FLAG_Z] = (ez == 0); ef[FLAG_N] = ez[31]; end
        mflags = ef;
    endtask

    task automatic drive(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input logic [29:0] p);
        in_valid = 1'b1; op = o; x = a; y = b; shamt = s; pc_in = p;
    endtask

    task automatic run_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] s, input logic [29:0] p);
        int n;
        bit stall_ok;
        model(o, a, b, s, p);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        drive(o, a, b, s, p);
        @(posedge clk); #1 in_valid = 1'b0;
        n = 0; stall_ok = 1;
        do begin
            @(negedge clk); n++;
            if (!out_valid && (in_ready || !busy)) stall_ok = 0;
        end while (!out_valid && n < 40);
        chk($sformatf("latency op%0d", o), n, (o == OP_MUL) ? 33 : 1);
        if (o == OP_MUL) chk("mul_stall", stall_ok, 1);
        chk($sformatf("z op%0d", o), z, ez);
        chk($sformatf("flags op%0d", o), flags, ef);
        chk($sformatf("br op%0d", o), branch_taken, ebr);
        chk($sformatf("addr op%0d", o), branch_addr, eaddr);
        chk($sformatf("ill op%0d", o), illegal, eill);
    endtask

    initial begin
        logic [31:0] z1;
        logic [3:0]  f1;
        logic [5:0]  ro;
        logic [31:0] ra;

        repeat (3) @(negedge clk);
        chk("reset_outs", {out_valid, z, flags, branch_taken, branch_addr, illegal, busy}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);

        run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 0, 0);
        chk("add_z", z, 32'h8000_0000);
        chk("add_flags", flags, 4'b0101);

        run_op(OP_SUB, 32'd5, 32'd5, 0, 0);
        chk("sub_flags", flags, 4'b0010);
        run_op(OP_SRA, 32'h8000_0000, 32'd0, 5'd4, 0);
        chk("sra_z", z, 32'hF800_0000);
        chk("sra_flags", flags, 4'b0001);

        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 0, 0);
        chk("mul_flags", flags, 4'b1110);

        // backpressure: first result held, second op stalled for 3 cycles
        @(negedge clk);
        out_ready = 1'b0;
        model(OP_ADD, 32'd100, 32'd23, 0, 0);
        z1 = ez; f1 = ef;
        drive(OP_ADD, 32'd100, 32'd23, 0, 0);
        @(posedge clk); #1;
        drive(OP_SUB, 32'd3, 32'd10, 0, 0);
        model(OP_SUB, 32'd3, 32'd10, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_z", z, z1);
            chk("bp_hold_f", flags, f1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_z", z, ez);
        chk("bp_second_f", flags, ef);

        // flush in cycle 10 of a multiply
        @(negedge clk);
        drive(OP_MUL, 32'd7, 32'd9, 0, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) @(negedge clk);
        chk("flush_busy_before", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_flags", flags, mflags);
        chk("flush_in_ready", in_ready, 1);
        repeat (30) @(negedge clk);
        chk("flush_no_late_result", out_valid, 0);

        // flush discards a same-cycle accept
        drive(OP_ADD, 32'd1, 32'd1, 0, 0);
        flush = 1'b1;
        @(posedge clk); #1 begin flush = 1'b0; in_valid = 1'b0; end
        @(negedge clk);
        chk("flush_accept_dropped", out_valid, 0);

        // reset pulse mid-multiply
        drive(OP_MUL, 32'hFFFF_FFFF, 32'd3, 0, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mul", {out_valid, z, flags, branch_taken, branch_addr, illegal, busy}, '0);
        mflags = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        run_op(OP_BEQ, 32'd0, 32'd3, 0, 30'h100);
        chk("beq_taken", branch_taken, 1);
        chk("beq_addr", branch_addr, 30'h10C);
        run_op(OP_BNE, 32'd0, 32'd3, 0, 30'h100);
        chk("bne_taken", branch_taken, 0);
        run_op(6'd40, 32'd55, 32'd66, 0, 0);
        chk("unknown_ill", illegal, 1);
        chk("unknown_z", z, 0);

        for (int i = 0; i < 150; i++) begin
            ro = (i % 10 == 9) ? OP_MUL : 6'($urandom_range(0, 40));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) - 32'd1 : $urandom;
            run_op(ro, ra, $urandom, 5'($urandom), 30'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
